// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store over a req/ack data bus with stall, fault detection and bus timeout.
// Bus fields are latched on leaving IDLE and held until the transfer ends.
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        lsu_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          to_q, we_q;
    logic [3:0]    be_q, be_d;
    logic [31:0]   ld_q, addr_q, wdata_q, wdata_d, ld_fmt;
    logic [15:0]   h16;
    logic [7:0]    b8;
    logic          access, fault, tmo;
    always_comb begin
        access  = mem_read | mem_write;
        fault   = (mem_read & mem_write) | (funct3[1:0] == 2'b11) | (funct3[2] & (funct3[1] | mem_write))
                | ((funct3[1:0] == 2'b01) & ALU_result[0]) | ((funct3[1:0] == 2'b10) & (|ALU_result[1:0]));
        be_d    = funct3[1] ? 4'b1111 : funct3[0] ? (ALU_result[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALU_result[1:0];
        wdata_d = funct3[1] ? rs2_data : funct3[0] ? {2{rs2_data[15:0]}} : {4{rs2_data[7:0]}};
        b8      = bus_rdata[{off_q, 3'b000} +: 8];
        h16     = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_fmt  = f3_q[1] ? bus_rdata : f3_q[0] ? {{16{~f3_q[2] & h16[15]}}, h16} : {{24{~f3_q[2] & b8[7]}}, b8};
        tmo     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    end
    // Gated by rst_n so a held mem_read cannot raise stall while the core is in reset.
    assign stall     = rst_n & (((state_q == IDLE) & access & ~fault) | (state_q == REQ));
    assign lsu_fault = rst_n & (((state_q == IDLE) & access & fault) | ((state_q == DONE) & to_q));
    assign bus_req   = state_q == REQ;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign load_data = ld_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            ld_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (access & ~fault) begin
                    state_q <= REQ;
                    addr_q  <= {ALU_result[31:2], 2'b00};
                    we_q    <= mem_write;
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    f3_q    <= funct3;
                    off_q   <= ALU_result[1:0];
                end
                REQ: if (bus_ack | tmo) begin
                    state_q <= DONE;
                    cnt_q   <= '0;
                    ld_q    <= (bus_ack & ~we_q) ? ld_fmt : '0;
                    to_q    <= ~bus_ack;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    to_q    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random RV32I accesses against a plain-arithmetic reference model.
module tb_load_store_unit;
    localparam int TO = 16;
    logic        clk = 0, rst_n = 0;
    logic [31:0] ALU_result = 0, rs2_data = 0, bus_rdata = 0;
    logic [2:0]  funct3 = 0;
    logic        mem_read = 0, mem_write = 0, bus_ack = 0;
    logic        stall, lsu_fault, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    int cmps = 0, errs = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ALU_result(ALU_result), .rs2_data(rs2_data), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .stall(stall), .load_data(load_data),
        .lsu_fault(lsu_fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return (rd && wr) || !legal || (a % m_size(f3) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(i % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, d);
        int sz = m_size(f3);
        logic [31:0] mask, v;
        if (sz == 4) return d;
        mask = (32'd1 << (8 * sz)) - 1;
        v = (d >> (8 * (a % 4))) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access; lat = REQ cycles before ack, lat >= TO means the slave never answers.
    task automatic run_access(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, rs2, rdata, input int lat, input string nm);
        bit flt, to;
        int n, stl;
        logic [31:0] exp_ld;
        flt = m_fault(rd, wr, f3, a);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; ALU_result = a; rs2_data = rs2;
        #1;
        cmps++; if (stall !== !flt) begin errs++; $display("FAIL %s idle_stall: got %b want %b", nm, stall, !flt); end
        cmps++; if (lsu_fault !== flt) begin errs++; $display("FAIL %s idle_fault: got %b want %b", nm, lsu_fault, flt); end
        cmps++; if (bus_req !== 1'b0) begin errs++; $display("FAIL %s idle_req: got %b want 0", nm, bus_req); end
        if (flt) begin
            bus_ack = 1;
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0; #1;
            cmps++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL %s fault_after: got req=%b stall=%b want 0 0", nm, bus_req, stall); end
            bus_ack = 0;
            return;
        end
        n = 0; stl = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (!bus_req) break;
            n++; stl += stall;
            cmps++; if (bus_addr !== {a[31:2], 2'b00} || bus_we !== wr || bus_be !== m_be(f3, a))
                begin errs++; $display("FAIL %s bus_fields: got addr=%h we=%b be=%b want addr=%h we=%b be=%b", nm, bus_addr, bus_we, bus_be, {a[31:2], 2'b00}, wr, m_be(f3, a)); end
            if (wr) begin
                cmps++; if (bus_wdata !== m_wdata(f3, rs2)) begin errs++; $display("FAIL %s wdata: got %h want %h", nm, bus_wdata, m_wdata(f3, rs2)); end
            end
            bus_ack = (lat < TO) && (n == lat + 1);
            bus_rdata = bus_ack ? rdata : $urandom;
        end
        bus_ack = 0;
        to = lat >= TO;
        exp_ld = (rd && !to) ? m_load(f3, a, rdata) : 32'd0;
        cmps++; if (n !== (to ? TO : lat + 1)) begin errs++; $display("FAIL %s req_cycles: got %0d want %0d", nm, n, to ? TO : lat + 1); end
        cmps++; if (stl !== n + 1) begin errs++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stl, n + 1); end
        cmps++; if (stall !== 1'b0 || lsu_fault !== to) begin errs++; $display("FAIL %s done: got stall=%b fault=%b want 0 %b", nm, stall, lsu_fault, to); end
        cmps++; if (load_data !== exp_ld) begin errs++; $display("FAIL %s load_data: got %h want %h", nm, load_data, exp_ld); end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; #1;
        cmps++; if (bus_req !== 1'b0 || stall !== 1'b0 || lsu_fault !== 1'b0) begin errs++; $display("FAIL %s reissue: got req=%b stall=%b fault=%b want 0 0 0", nm, bus_req, stall, lsu_fault); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        cmps++; if ({stall, lsu_fault, bus_req, bus_we} !== 4'b0) begin errs++; $display("FAIL reset_ctrl: got %b want 0000", {stall, lsu_fault, bus_req, bus_we}); end
        cmps++; if (load_data !== 0 || bus_addr !== 0 || bus_wdata !== 0 || bus_be !== 0) begin errs++; $display("FAIL reset_data: got ld=%h addr=%h wd=%h be=%b want 0", load_data, bus_addr, bus_wdata, bus_be); end
        rst_n = 1;
    endtask

    task automatic test_store();
        run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, "sw_100");
        run_access(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, "sb_203");
        run_access(0, 1, 3'b001, 32'h206, 32'h1234CAFE, 0, 3, "sh_206");
    endtask

    task automatic test_load();
        run_access(1, 0, 3'b000, 32'h302, 0, 32'h12F45678, 0, "lb_302");
        run_access(1, 0, 3'b100, 32'h302, 0, 32'h12F45678, 2, "lbu_302");
        run_access(1, 0, 3'b101, 32'h302, 0, 32'h12F45678, 1, "lhu_302");
        run_access(1, 0, 3'b001, 32'h300, 0, 32'h12F48678, 0, "lh_300");
        run_access(1, 0, 3'b010, 32'h304, 0, 32'h87654321, 4, "lw_304");
    endtask

    task automatic test_fault();
        run_access(1, 0, 3'b010, 32'h101, 0, 0, 0, "lw_101");
        run_access(1, 0, 3'b001, 32'h103, 0, 0, 0, "lh_103");
        run_access(0, 1, 3'b100, 32'h100, 1, 0, 0, "st_f3_100");
        run_access(1, 0, 3'b011, 32'h100, 0, 0, 0, "ld_f3_011");
        run_access(1, 1, 3'b010, 32'h100, 0, 0, 0, "rd_and_wr");
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h500, 0, 32'h11223344, TO, "lw_timeout");
        run_access(1, 0, 3'b010, 32'h504, 0, 32'h55667788, TO - 1, "lw_ack_last");
        run_access(0, 1, 3'b010, 32'h508, 32'hA5A5A5A5, 0, TO + 3, "sw_timeout");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_read = 1; funct3 = 3'b010; ALU_result = 32'h400;
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        cmps++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL mid_reset: got req=%b stall=%b want 0 0", bus_req, stall); end
        mem_read = 0;
        @(posedge clk); #2 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cmps++; if (bus_req !== 1'b0 || stall !== 1'b0 || lsu_fault !== 1'b0) begin errs++; $display("FAIL post_reset_%0d: got req=%b stall=%b fault=%b want 0 0 0", i, bus_req, stall, lsu_fault); end
        end
        run_access(0, 1, 3'b010, 32'h600, 32'h0BADF00D, 0, 1, "sw_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1)) a[1:0] = 2'b00;
            run_access(r == 0 || r < 5, r == 0 || r >= 5, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                       ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 5), $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the single-cycle core.
- Takes ALU_result as the effective address and performs RV32I loads and stores over a req/ack data-memory bus.
- Stalls the core while a transfer is outstanding, then returns sign- or zero-extended load data to writeback.
- Detects misaligned and illegal accesses, and aborts bus transfers that never complete.

Parameters:
- TIMEOUT, 16: cycles to wait for bus_ack in REQ before aborting; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1): width of the timeout counter; derived, never overridden.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ALU_result  in  32  effective address from the ALU.
- rs2_data  in  32  store source register value.
- funct3  in  3  access size/sign (RV32I load/store encoding).
- mem_read  in  1  control: load instruction in this cycle.
- mem_write  in  1  control: store instruction in this cycle.
- stall  out  1  hold PC and pipeline state.
- load_data  out  32  formatted load result; valid while state is DONE.
- lsu_fault  out  1  one-cycle pulse: misaligned, illegal funct3, read+write together, or bus timeout.
- bus_req  out  1  memory request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {ALU_result[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transfer complete.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. stall, load_data, lsu_fault, bus_req, bus_we, bus_addr, bus_be and bus_wdata are all 0.
- Reset mid-transfer: bus_req drops immediately and no DONE is produced.
- access = mem_read | mem_write.
- Fault check, evaluated combinationally in IDLE:
  - mem_read & mem_write together.
  - funct3 in {011,110,111}; for stores, also funct3 in {100,101}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- IDLE:
  - access with a fault: lsu_fault=1 this cycle, stall=0, no bus activity, remain IDLE.
  - access without a fault: stall=1 combinationally in the same cycle. Register bus_addr, bus_we, bus_be, bus_wdata, funct3 and addr[1:0]; go to REQ.
- REQ:
  - bus_req=1 and stall=1. Bus fields are held stable until ack.
  - On bus_ack: register the formatted load_data (stores leave load_data=0), drop bus_req, go to DONE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack: drop bus_req, load_data=0, lsu_fault=1 in DONE, go to DONE.
  - The counter increments each REQ cycle and clears on leaving REQ.
  - An ack on the same cycle the counter hits its limit counts as a success.
- DONE:
  - stall=0 for one cycle so the core commits.
  - Always returns to IDLE; the still-asserted mem_read/mem_write is ignored in DONE, so there is no re-issue.
  - Every legal access therefore costs at least 3 cycles: IDLE→REQ (ack earliest in the first REQ cycle)→DONE.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=rs2, be=1111.
- Load formatting uses the latched offset:
  - LB/LBU: select byte offset, then sign-/zero-extend.
  - LH/LHU: select half addr[1], then extend.
  - LW: full word.
  - Load bus_be is set by size, as for stores.
- bus_ack outside REQ is ignored.

Test Plan:
- SW to 0x100 with rs2=0xDEADBEEF, ack 2 cycles after req → bus_be=1111, wdata=0xDEADBEEF, stall high for 3 cycles then one DONE cycle with stall=0.
- SB to 0x203, rs2=0x000000A5 → bus_addr=0x200, bus_be=1000, wdata=0xA5A5A5A5.
- LB from 0x302, rdata=0x12F45678 → load_data=0xFFFFFFF4. LBU at the same address → 0x000000F4. LHU from 0x302 → 0x000012F4.
- LW from 0x101 and LH from 0x103 → lsu_fault pulse, stall=0, bus_req never asserts.
- LW with TIMEOUT=16 and no ack → bus_req high exactly 16 cycles, then DONE with lsu_fault=1 and load_data=0. Ack arriving in the 16th cycle → normal completion.
- rst_n low while in REQ → bus_req and stall go 0 asynchronously. After release, a new SW completes normally with no spurious DONE.
